// File: rtl/hilo_muldiv_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hilo_muldiv_sequencer_if                                                 |
// | EX-stage <-> Hi/Lo multiply/divide sequencer signal bundle.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface hilo_muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic [2:0]       Op_Code;
    logic [WIDTH-1:0] RS_Value;
    logic [WIDTH-1:0] RT_Value;
    logic             MF_Request;
    logic             HiEnable;
    logic             LoEnable;
    logic [WIDTH-1:0] Hi_PW;
    logic [WIDTH-1:0] Lo_PW;
    logic             Busy;
    logic             Stall;

    modport master (
        output Op_Code, RS_Value, RT_Value, MF_Request,
        input  HiEnable, LoEnable, Hi_PW, Lo_PW, Busy, Stall
    );

    modport slave (
        input  Op_Code, RS_Value, RT_Value, MF_Request,
        output HiEnable, LoEnable, Hi_PW, Lo_PW, Busy, Stall
    );
endinterface
`default_nettype wire

// File: rtl/hilo_muldiv_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | hilo_muldiv_sequencer                                                    |
// | Iterative shift-add multiply / restoring divide owning Hi/Lo writes.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module hilo_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     Reset,
    hilo_muldiv_sequencer_if.slave   bus
);
    localparam int         c_cnt_w    = $clog2(WIDTH);
    localparam logic [2:0] c_op_none  = 3'b000;
    localparam logic [2:0] c_op_mult  = 3'b001;
    localparam logic [2:0] c_op_multu = 3'b010;
    localparam logic [2:0] c_op_div   = 3'b011;
    localparam logic [2:0] c_op_divu  = 3'b100;
    localparam logic [2:0] c_op_mthi  = 3'b101;
    localparam logic [2:0] c_op_mtlo  = 3'b110;
    localparam logic [2:0] c_op_nop7  = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    state_t               r_state_q,  w_state_d;
    logic [c_cnt_w-1:0]   r_cnt_q,    w_cnt_d;
    logic [WIDTH:0]       r_acc_q,    w_acc_d;
    logic [WIDTH-1:0]     r_lo_q,     w_lo_d;
    logic [WIDTH-1:0]     r_opnd_q,   w_opnd_d;
    logic                 r_is_div_q, w_is_div_d;
    logic                 r_neg_a_q,  w_neg_a_d;
    logic                 r_neg_r_q,  w_neg_r_d;
    logic                 r_hi_en_q,  w_hi_en_d;
    logic                 r_lo_en_q,  w_lo_en_d;
    logic [WIDTH-1:0]     r_hi_pw_q,  w_hi_pw_d;
    logic [WIDTH-1:0]     r_lo_pw_q,  w_lo_pw_d;

    logic                 w_signed_op;
    logic [WIDTH-1:0]     w_rs_mag;
    logic [WIDTH-1:0]     w_rt_mag;
    logic [WIDTH:0]       w_mul_sum;
    logic [WIDTH:0]       w_div_shift;
    logic [WIDTH:0]       w_div_diff;
    logic [WIDTH:0]       w_step_acc;
    logic [WIDTH-1:0]     w_step_lo;
    logic [2*WIDTH-1:0]   w_prod;
    logic [2*WIDTH-1:0]   w_prod_fix;
    logic [WIDTH-1:0]     w_quot;
    logic [WIDTH-1:0]     w_rem;

    // Datapath: one multiply or divide iteration on the shared acc/lo pair.
    always_comb begin
        w_signed_op = (bus.Op_Code == c_op_mult) || (bus.Op_Code == c_op_div);
        w_rs_mag    = (w_signed_op && bus.RS_Value[WIDTH-1]) ? (-bus.RS_Value) : bus.RS_Value;
        w_rt_mag    = (w_signed_op && bus.RT_Value[WIDTH-1]) ? (-bus.RT_Value) : bus.RT_Value;

        w_mul_sum   = r_acc_q + (r_lo_q[0] ? {1'b0, r_opnd_q} : '0);
        w_div_shift = {r_acc_q[WIDTH-1:0], r_lo_q[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_opnd_q};

        if (r_is_div_q) begin
            if (!w_div_diff[WIDTH]) begin
                w_step_acc = w_div_diff;
                w_step_lo  = {r_lo_q[WIDTH-2:0], 1'b1};
            end else begin
                w_step_acc = w_div_shift;
                w_step_lo  = {r_lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_step_acc = {1'b0, w_mul_sum[WIDTH:1]};
            w_step_lo  = {w_mul_sum[0], r_lo_q[WIDTH-1:1]};
        end

        // Signs are restored only on the final step's result.
        w_prod     = {w_step_acc[WIDTH-1:0], w_step_lo};
        w_prod_fix = r_neg_a_q ? (-w_prod) : w_prod;
        w_quot     = r_neg_a_q ? (-w_step_lo) : w_step_lo;
        w_rem      = r_neg_r_q ? (-w_step_acc[WIDTH-1:0]) : w_step_acc[WIDTH-1:0];
    end

    always_comb begin
        w_state_d  = r_state_q;
        w_cnt_d    = r_cnt_q;
        w_acc_d    = r_acc_q;
        w_lo_d     = r_lo_q;
        w_opnd_d   = r_opnd_q;
        w_is_div_d = r_is_div_q;
        w_neg_a_d  = r_neg_a_q;
        w_neg_r_d  = r_neg_r_q;
        w_hi_en_d  = 1'b0;
        w_lo_en_d  = 1'b0;
        w_hi_pw_d  = r_hi_pw_q;
        w_lo_pw_d  = r_lo_pw_q;

        case (r_state_q)
            ST_IDLE: begin
                case (bus.Op_Code)
                    c_op_mult, c_op_multu: begin
                        w_acc_d    = '0;
                        w_lo_d     = w_rt_mag;
                        w_opnd_d   = w_rs_mag;
                        w_is_div_d = 1'b0;
                        w_neg_a_d  = w_signed_op && (bus.RS_Value[WIDTH-1] ^ bus.RT_Value[WIDTH-1]);
                        w_neg_r_d  = 1'b0;
                        w_cnt_d    = c_cnt_w'(WIDTH-1);
                        w_state_d  = ST_RUN;
                    end
                    c_op_div, c_op_divu: begin
                        if (bus.RT_Value == '0) begin
                            w_hi_pw_d = bus.RS_Value;
                            w_lo_pw_d = '1;
                            w_hi_en_d = 1'b1;
                            w_lo_en_d = 1'b1;
                            w_state_d = ST_WRITE;
                        end else begin
                            w_acc_d    = '0;
                            w_lo_d     = w_rs_mag;
                            w_opnd_d   = w_rt_mag;
                            w_is_div_d = 1'b1;
                            w_neg_a_d  = w_signed_op && (bus.RS_Value[WIDTH-1] ^ bus.RT_Value[WIDTH-1]);
                            w_neg_r_d  = w_signed_op && bus.RS_Value[WIDTH-1];
                            w_cnt_d    = c_cnt_w'(WIDTH-1);
                            w_state_d  = ST_RUN;
                        end
                    end
                    c_op_mthi: begin
                        w_hi_pw_d = bus.RS_Value;
                        w_hi_en_d = 1'b1;
                        w_state_d = ST_WRITE;
                    end
                    c_op_mtlo: begin
                        w_lo_pw_d = bus.RS_Value;
                        w_lo_en_d = 1'b1;
                        w_state_d = ST_WRITE;
                    end
                    default: ;
                endcase
            end
            ST_RUN: begin
                w_acc_d = w_step_acc;
                w_lo_d  = w_step_lo;
                w_cnt_d = r_cnt_q - 1'b1;
                if (r_cnt_q == '0) begin
                    w_hi_pw_d = r_is_div_q ? w_rem  : w_prod_fix[2*WIDTH-1:WIDTH];
                    w_lo_pw_d = r_is_div_q ? w_quot : w_prod_fix[WIDTH-1:0];
                    w_hi_en_d = 1'b1;
                    w_lo_en_d = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = ST_WRITE;
                end
            end
            ST_WRITE: w_state_d = ST_IDLE;
            default:  w_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state_q  <= ST_IDLE;
            r_cnt_q    <= '0;
            r_acc_q    <= '0;
            r_lo_q     <= '0;
            r_opnd_q   <= '0;
            r_is_div_q <= 1'b0;
            r_neg_a_q  <= 1'b0;
            r_neg_r_q  <= 1'b0;
            r_hi_en_q  <= 1'b0;
            r_lo_en_q  <= 1'b0;
            r_hi_pw_q  <= '0;
            r_lo_pw_q  <= '0;
        end else begin
            r_state_q  <= w_state_d;
            r_cnt_q    <= w_cnt_d;
            r_acc_q    <= w_acc_d;
            r_lo_q     <= w_lo_d;
            r_opnd_q   <= w_opnd_d;
            r_is_div_q <= w_is_div_d;
            r_neg_a_q  <= w_neg_a_d;
            r_neg_r_q  <= w_neg_r_d;
            r_hi_en_q  <= w_hi_en_d;
            r_lo_en_q  <= w_lo_en_d;
            r_hi_pw_q  <= w_hi_pw_d;
            r_lo_pw_q  <= w_lo_pw_d;
        end
    end

    assign bus.HiEnable = r_hi_en_q;
    assign bus.LoEnable = r_lo_en_q;
    assign bus.Hi_PW    = r_hi_pw_q;
    assign bus.Lo_PW    = r_lo_pw_q;
    assign bus.Busy     = (r_state_q != ST_IDLE);
    // Ops arriving in IDLE are accepted at once, so only a busy sequencer stalls.
    assign bus.Stall    = (((bus.Op_Code != c_op_none) && (bus.Op_Code != c_op_nop7)) || bus.MF_Request)
                          && (r_state_q != ST_IDLE);
endmodule
`default_nettype wire
